// File: rtl/cache_set.sv
// N-way set-associative cache set: parallel tag compare, one-cycle lookup response,
// tree pseudo-LRU victim selection and word-wise line fill.

module cache_way #(
  parameter int OW        = 4,
  parameter int TAG_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 inv,
  input  logic                 fill_en,
  input  logic                 fill_last,
  input  logic [OW-1:0]        fill_off,
  input  logic [31:0]          fill_data,
  input  logic [TAG_WIDTH-1:0] fill_tag,
  input  logic                 st_en,
  input  logic [OW-1:0]        lk_off,
  input  logic [31:0]          lk_wdata,
  input  logic [3:0]           lk_be,
  input  logic [TAG_WIDTH-1:0] lk_tag,
  output logic                 hit,
  output logic [31:0]          rdata,
  output logic [TAG_WIDTH-1:0] tag,
  output logic                 valid,
  output logic                 dirty
);
  logic [31:0] mem [2**OW];

  assign hit   = valid & (tag == lk_tag);
  assign rdata = mem[lk_off];

  // Data RAM carries no reset; fill and store never coincide since a fill blocks lookups.
  always_ff @(posedge clk) begin
    if (fill_en)
      mem[fill_off] <= fill_data;
    else if (st_en)
      for (int b = 0; b < 4; b++)
        if (lk_be[b]) mem[lk_off][8*b +: 8] <= lk_wdata[8*b +: 8];
  end

  // A non-final fill word drops valid so a partially written line never hits.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tag   <= '0;
      valid <= 1'b0;
      dirty <= 1'b0;
    end else if (inv) begin
      valid <= 1'b0;
      dirty <= 1'b0;
    end else if (fill_en) begin
      if (fill_last) begin
        tag   <= fill_tag;
        valid <= 1'b1;
        dirty <= 1'b0;
      end else begin
        valid <= 1'b0;
      end
    end else if (st_en) begin
      dirty <= 1'b1;
    end
  end
endmodule

module cache_set #(
  parameter int WAYS       = 4,
  parameter int LINE_WIDTH = 6,
  parameter int TAG_WIDTH  = 20,
  localparam int OW = LINE_WIDTH - 2,
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 lk_req,
  output logic                 lk_ready,
  input  logic [TAG_WIDTH-1:0] lk_tag,
  input  logic [OW-1:0]        lk_off,
  input  logic                 lk_write,
  input  logic [31:0]          lk_wdata,
  input  logic [3:0]           lk_be,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [WW-1:0]        rsp_way,
  output logic [31:0]          rsp_data,
  output logic [WW-1:0]        vic_way,
  output logic [TAG_WIDTH-1:0] vic_tag,
  output logic                 vic_valid,
  output logic                 vic_dirty,
  input  logic                 fill_we,
  input  logic [WW-1:0]        fill_way,
  input  logic [OW-1:0]        fill_off,
  input  logic [31:0]          fill_data,
  input  logic [TAG_WIDTH-1:0] fill_tag,
  input  logic                 fill_last,
  input  logic                 inv
);
  localparam int LG = $clog2(WAYS);
  localparam int PN = (WAYS > 1) ? WAYS - 1 : 1;

  logic [WAYS-1:0]                hits, valids, dirtys;
  logic [WAYS-1:0][31:0]          rdatas;
  logic [WAYS-1:0][TAG_WIDTH-1:0] tags;
  logic [WW-1:0]                  hit_way, plru_way;
  logic [PN-1:0]                  plru;
  logic                           acc, any_hit;

  assign lk_ready = ~fill_we & ~inv;
  assign acc      = lk_req & lk_ready;
  assign any_hit  = |hits;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(.OW(OW), .TAG_WIDTH(TAG_WIDTH)) u_way (
      .clk       (clk),
      .nrst      (nrst),
      .inv       (inv),
      .fill_en   (fill_we & ~inv & (fill_way == WW'(w))),
      .fill_last (fill_last),
      .fill_off  (fill_off),
      .fill_data (fill_data),
      .fill_tag  (fill_tag),
      .st_en     (acc & lk_write & hits[w]),
      .lk_off    (lk_off),
      .lk_wdata  (lk_wdata),
      .lk_be     (lk_be),
      .lk_tag    (lk_tag),
      .hit       (hits[w]),
      .rdata     (rdatas[w]),
      .tag       (tags[w]),
      .valid     (valids[w]),
      .dirty     (dirtys[w])
    );
  end

  // Heap-ordered tree: node n (1-based) has children 2n, 2n+1; bit 1 points at the upper half.
  function automatic logic [PN-1:0] touch(input logic [PN-1:0] t, input logic [WW-1:0] w);
    logic [PN-1:0] r;
    int n;
    r = t;
    n = 1;
    for (int l = 0; l < LG; l++) begin
      r[n-1] = ~w[LG-1-l];
      n = 2*n + int'(w[LG-1-l]);
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] follow(input logic [PN-1:0] t);
    logic [WW-1:0] v;
    int n;
    v = '0;
    n = 1;
    for (int l = 0; l < LG; l++) begin
      v[LG-1-l] = t[n-1];
      n = 2*n + int'(t[n-1]);
    end
    return v;
  endfunction

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (hits[w]) hit_way = hit_way | WW'(w);
  end

  assign plru_way = follow(plru);

  always_comb begin
    vic_way = plru_way;
    for (int w = WAYS-1; w >= 0; w--)
      if (!valids[w]) vic_way = WW'(w);
  end

  assign vic_tag   = tags[vic_way];
  assign vic_valid = valids[vic_way];
  assign vic_dirty = valids[vic_way] & dirtys[vic_way];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      plru <= '0;
    else if (inv)
      plru <= '0;
    else if (fill_we & fill_last)
      plru <= touch(plru, fill_way);
    else if (acc & any_hit)
      plru <= touch(plru, hit_way);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= acc;
      rsp_hit   <= acc & any_hit;
      rsp_way   <= (acc & any_hit) ? hit_way : '0;
      rsp_data  <= (acc & any_hit & ~lk_write) ? rdatas[hit_way] : '0;
    end
  end
endmodule

// File: tb/tb_cache_set.sv
// Self-checking bench for cache_set: directed scenarios plus a randomized run
// compared against an array/tree model of the set.
module tb_cache_set;
  logic        clk = 1'b0, nrst = 1'b0;
  logic        lk_req, lk_write, fill_we, fill_last, inv;
  logic [19:0] lk_tag, fill_tag;
  logic [3:0]  lk_off, fill_off, lk_be;
  logic [31:0] lk_wdata, fill_data;
  logic [1:0]  fill_way;
  logic        lk_ready, rsp_valid, rsp_hit, vic_valid, vic_dirty;
  logic [1:0]  rsp_way, vic_way;
  logic [31:0] rsp_data;
  logic [19:0] vic_tag;

  int errors = 0, checks = 0;

  cache_set #(.WAYS(4), .LINE_WIDTH(6), .TAG_WIDTH(20)) dut (
    .clk(clk), .nrst(nrst),
    .lk_req(lk_req), .lk_ready(lk_ready), .lk_tag(lk_tag), .lk_off(lk_off),
    .lk_write(lk_write), .lk_wdata(lk_wdata), .lk_be(lk_be),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_data(rsp_data),
    .vic_way(vic_way), .vic_tag(vic_tag), .vic_valid(vic_valid), .vic_dirty(vic_dirty),
    .fill_we(fill_we), .fill_way(fill_way), .fill_off(fill_off), .fill_data(fill_data),
    .fill_tag(fill_tag), .fill_last(fill_last), .inv(inv)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays; PLRU as per-level node bits keyed by way-index prefix.
  logic [19:0] m_tag [4];
  bit          m_valid [4], m_dirty [4];
  logic [31:0] m_data [4][16];
  bit          m_pl [2][2];
  bit          e_valid, e_hit;
  logic [1:0]  e_way;
  logic [31:0] e_data;

  function automatic void m_reset();
    for (int w = 0; w < 4; w++) begin
      m_tag[w] = '0; m_valid[w] = 0; m_dirty[w] = 0;
    end
    for (int l = 0; l < 2; l++) begin m_pl[l][0] = 0; m_pl[l][1] = 0; end
  endfunction

  function automatic void m_touch(int w);
    for (int l = 0; l < 2; l++) m_pl[l][w >> (2-l)] = !((w >> (1-l)) & 1);
  endfunction

  function automatic int m_vic();
    int p = 0;
    for (int w = 0; w < 4; w++) if (!m_valid[w]) return w;
    for (int l = 0; l < 2; l++) p = p*2 + int'(m_pl[l][p]);
    return p;
  endfunction

  task automatic idle();
    lk_req = 0; lk_write = 0; lk_tag = '0; lk_off = '0; lk_wdata = '0; lk_be = '0;
    fill_we = 0; fill_last = 0; fill_way = '0; fill_off = '0; fill_data = '0; fill_tag = '0;
    inv = 0;
  endtask

  // Advance one clock: predict response and update the model from the driven inputs.
  task automatic step();
    bit acc, h;
    int hw;
    acc = lk_req && !fill_we && !inv;
    h = 0; hw = 0;
    for (int w = 0; w < 4; w++) if (m_valid[w] && m_tag[w] == lk_tag) begin h = 1; hw = w; end
    e_valid = acc;
    e_hit   = acc && h;
    e_way   = (acc && h) ? 2'(hw) : 2'd0;
    e_data  = (acc && h && !lk_write) ? m_data[hw][lk_off] : 32'd0;
    if (inv) begin
      for (int w = 0; w < 4; w++) begin m_valid[w] = 0; m_dirty[w] = 0; end
      for (int l = 0; l < 2; l++) begin m_pl[l][0] = 0; m_pl[l][1] = 0; end
    end else if (fill_we) begin
      m_data[fill_way][fill_off] = fill_data;
      if (fill_last) begin
        m_tag[fill_way] = fill_tag; m_valid[fill_way] = 1; m_dirty[fill_way] = 0;
        m_touch(int'(fill_way));
      end else m_valid[fill_way] = 0;
    end else if (acc && h) begin
      if (lk_write) begin
        for (int b = 0; b < 4; b++) if (lk_be[b]) m_data[hw][lk_off][8*b +: 8] = lk_wdata[8*b +: 8];
        m_dirty[hw] = 1;
      end
      m_touch(hw);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    nrst = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 nrst = 1;
  endtask

  task automatic fill_words(input int way, input logic [19:0] tag, input logic [31:0] base,
                            input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      idle();
      fill_we = 1; fill_way = 2'(way); fill_off = 4'(i); fill_data = base + 32'(i);
      fill_tag = tag; fill_last = last && (i == n-1);
      step();
    end
    idle();
  endtask

  task automatic lookup(input logic [19:0] tag, input int off);
    idle();
    lk_req = 1; lk_tag = tag; lk_off = 4'(off);
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    nrst = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 0 || rsp_hit !== 0 || rsp_way !== 0 || rsp_data !== 0) begin errors++; $display("FAIL reset_rsp got v=%0b h=%0b w=%0d d=%h want all 0", rsp_valid, rsp_hit, rsp_way, rsp_data); end
    checks++; if (vic_way !== 0 || vic_valid !== 0 || vic_dirty !== 0) begin errors++; $display("FAIL reset_vic got way=%0d v=%0b d=%0b want 0", vic_way, vic_valid, vic_dirty); end
    checks++; if (lk_ready !== 1) begin errors++; $display("FAIL reset_ready got %0b want 1", lk_ready); end
    nrst = 1;
    lookup(20'h12345, 3);
    checks++; if (rsp_valid !== 1 || rsp_hit !== 0 || rsp_data !== 0) begin errors++; $display("FAIL cold_miss got v=%0b h=%0b d=%h want 1 0 0", rsp_valid, rsp_hit, rsp_data); end
    checks++; if (vic_way !== 0 || vic_valid !== 0) begin errors++; $display("FAIL cold_vic got way=%0d v=%0b want 0 0", vic_way, vic_valid); end
    step();
    checks++; if (rsp_valid !== 0) begin errors++; $display("FAIL idle_rsp got %0b want 0", rsp_valid); end
  endtask

  task automatic test_fill_read();
    fill_words(2, 20'hABCDE, 32'h100, 16, 1);
    lookup(20'hABCDE, 5);
    checks++; if (rsp_valid !== 1 || rsp_hit !== 1 || rsp_way !== 2 || rsp_data !== 32'h105) begin errors++; $display("FAIL fill_read got v=%0b h=%0b w=%0d d=%h want 1 1 2 00000105", rsp_valid, rsp_hit, rsp_way, rsp_data); end
    checks++; if (vic_dirty !== 0 || vic_way !== 0) begin errors++; $display("FAIL fill_vic got way=%0d dirty=%0b want 0 0", vic_way, vic_dirty); end
  endtask

  task automatic test_store();
    idle();
    lk_req = 1; lk_write = 1; lk_tag = 20'hABCDE; lk_off = 4'd5; lk_wdata = 32'hFFFFFFFF; lk_be = 4'b0011;
    step();
    lk_write = 0; lk_be = '0; lk_wdata = '0;
    checks++; if (rsp_valid !== 1 || rsp_hit !== 1 || rsp_way !== 2 || rsp_data !== 0) begin errors++; $display("FAIL store_rsp got v=%0b h=%0b w=%0d d=%h want 1 1 2 0", rsp_valid, rsp_hit, rsp_way, rsp_data); end
    step();
    idle();
    checks++; if (rsp_hit !== 1 || rsp_data !== 32'h0000FFFF) begin errors++; $display("FAIL store_merge got h=%0b d=%h want 1 0000ffff", rsp_hit, rsp_data); end
    fill_words(0, 20'h11111, 32'h000, 16, 1);
    fill_words(1, 20'h22222, 32'h200, 16, 1);
    fill_words(3, 20'h33333, 32'h300, 16, 1);
    lookup(20'h11111, 0);
    lookup(20'h22222, 0);
    checks++; if (vic_way !== 2 || vic_valid !== 1 || vic_dirty !== 1 || vic_tag !== 20'hABCDE) begin errors++; $display("FAIL dirty_vic got way=%0d v=%0b d=%0b tag=%h want 2 1 1 abcde", vic_way, vic_valid, vic_dirty, vic_tag); end
  endtask

  task automatic test_back_to_back_plru();
    logic [19:0] tg [4];
    tg[0] = 20'h11111; tg[1] = 20'h22222; tg[2] = 20'hABCDE; tg[3] = 20'h33333;
    for (int w = 0; w < 4; w++) begin
      idle();
      lk_req = 1; lk_tag = tg[w]; lk_off = 4'(w + 1);
      step();
      checks++; if (rsp_valid !== 1 || rsp_hit !== 1 || rsp_way !== 2'(w)) begin errors++; $display("FAIL b2b_way%0d got v=%0b h=%0b w=%0d", w, rsp_valid, rsp_hit, rsp_way); end
    end
    idle();
    checks++; if (vic_way !== 0) begin errors++; $display("FAIL plru_0123 got %0d want 0", vic_way); end
    lookup(tg[0], 0);
    checks++; if (vic_way !== 2) begin errors++; $display("FAIL plru_hit0 got %0d want 2", vic_way); end
  endtask

  task automatic test_fill_block();
    idle();
    fill_we = 1; fill_way = 2'd1; fill_off = 4'd0; fill_data = 32'h777; fill_tag = 20'h77777;
    lk_req = 1; lk_tag = 20'h22222;
    #1;
    checks++; if (lk_ready !== 0) begin errors++; $display("FAIL fill_ready got %0b want 0", lk_ready); end
    step();
    checks++; if (rsp_valid !== 0) begin errors++; $display("FAIL fill_block_rsp got %0b want 0", rsp_valid); end
    lookup(20'h22222, 0);
    checks++; if (rsp_valid !== 1 || rsp_hit !== 0) begin errors++; $display("FAIL partial_miss got v=%0b h=%0b want 1 0", rsp_valid, rsp_hit); end
    checks++; if (vic_way !== 1 || vic_valid !== 0) begin errors++; $display("FAIL partial_vic got way=%0d v=%0b want 1 0", vic_way, vic_valid); end
  endtask

  task automatic test_inv();
    idle();
    fill_we = 1; fill_way = 2'd1; fill_off = 4'd15; fill_data = 32'h444; fill_tag = 20'h44444; fill_last = 1;
    inv = 1; lk_req = 1; lk_tag = 20'h11111;
    #1;
    checks++; if (lk_ready !== 0) begin errors++; $display("FAIL inv_ready got %0b want 0", lk_ready); end
    step();
    idle();
    checks++; if (rsp_valid !== 0 || vic_valid !== 0 || vic_way !== 0 || vic_dirty !== 0) begin errors++; $display("FAIL inv_state got v=%0b vv=%0b way=%0d vd=%0b want 0", rsp_valid, vic_valid, vic_way, vic_dirty); end
    lookup(20'h44444, 15);
    checks++; if (rsp_valid !== 1 || rsp_hit !== 0) begin errors++; $display("FAIL inv_filltag got v=%0b h=%0b want 1 0", rsp_valid, rsp_hit); end
    lookup(20'hABCDE, 5);
    checks++; if (rsp_hit !== 0 || rsp_data !== 0) begin errors++; $display("FAIL inv_old got h=%0b d=%h want 0 0", rsp_hit, rsp_data); end
  endtask

  task automatic test_reset_midfill();
    fill_words(1, 20'h55555, 32'h500, 16, 1);
    lookup(20'h55555, 9);
    checks++; if (rsp_hit !== 1 || rsp_way !== 1 || rsp_data !== 32'h509) begin errors++; $display("FAIL refill_hit got h=%0b w=%0d d=%h want 1 1 00000509", rsp_hit, rsp_way, rsp_data); end
    fill_words(1, 20'h66666, 32'h600, 7, 0);
    lookup(20'h55555, 0);
    checks++; if (rsp_valid !== 1 || rsp_hit !== 0) begin errors++; $display("FAIL midfill_miss got v=%0b h=%0b want 1 0", rsp_valid, rsp_hit); end
    nrst = 0;
    m_reset();
    #1;
    checks++; if (rsp_valid !== 0) begin errors++; $display("FAIL async_rst_rsp got %0b want 0", rsp_valid); end
    @(posedge clk); #1 nrst = 1;
    lookup(20'h66666, 0);
    checks++; if (rsp_valid !== 1 || rsp_hit !== 0 || vic_way !== 0 || vic_valid !== 0) begin errors++; $display("FAIL rst_abort got v=%0b h=%0b way=%0d vv=%0b want 1 0 0 0", rsp_valid, rsp_hit, vic_way, vic_valid); end
  endtask

  task automatic test_random();
    bit fa = 0;
    int fw = 0, fo = 0, ntag = 0, r;
    logic [19:0] ft = '0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      idle();
      lk_req   = ($urandom_range(0, 9) != 0);
      lk_tag   = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 20'h7FFFF)) : m_tag[$urandom_range(0, 3)];
      lk_off   = 4'($urandom_range(0, 15));
      lk_write = ($urandom_range(0, 2) == 0);
      lk_be    = 4'($urandom_range(0, 15));
      lk_wdata = $urandom;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        inv = 1; fa = 0;
      end else if ((fa && r < 50) || (!fa && r < 10)) begin
        if (!fa) begin fa = 1; fw = $urandom_range(0, 3); ft = 20'h80000 + 20'(ntag); ntag++; fo = 0; end
        fill_we = 1; fill_way = 2'(fw); fill_off = 4'(fo); fill_data = $urandom;
        fill_tag = ft; fill_last = (fo == 15);
        fo++;
        if (fo == 16) fa = 0;
      end
      #1;
      checks++; if (lk_ready !== !(fill_we || inv)) begin errors++; $display("FAIL rnd_ready c=%0d got %0b", c, lk_ready); end
      step();
      checks++; if (rsp_valid !== e_valid || rsp_hit !== e_hit || rsp_way !== e_way || rsp_data !== e_data) begin errors++; $display("FAIL rnd_rsp c=%0d got v=%0b h=%0b w=%0d d=%h want %0b %0b %0d %h", c, rsp_valid, rsp_hit, rsp_way, rsp_data, e_valid, e_hit, e_way, e_data); end
      checks++; if (vic_way !== 2'(m_vic()) || vic_valid !== m_valid[m_vic()] || vic_dirty !== (m_valid[m_vic()] && m_dirty[m_vic()]) || vic_tag !== m_tag[m_vic()]) begin errors++; $display("FAIL rnd_vic c=%0d got way=%0d v=%0b d=%0b tag=%h want way=%0d", c, vic_way, vic_valid, vic_dirty, vic_tag, m_vic()); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill_read();
    test_store();
    test_back_to_back_plru();
    test_fill_block();
    test_inv();
    test_reset_midfill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
